// File: rtl/lin1d_sched_if.sv
// Stream bundle between the IQ source, the lin1d_sched scheduler and the two-tap interpolator.
// The slave side is the scheduler; the master side is whatever drives it (source + sink).
interface lin1d_sched_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 10,
  parameter int INT_BITS   = 4
);
  localparam int STEP_W = INT_BITS + FRAC_BITS;

  logic [STEP_W-1:0]       cfg_step;
  logic                    cfg_load;

  logic [2*DATA_WIDTH-1:0] i_tdata;
  logic                    i_tvalid;
  logic                    i_tlast;
  logic                    i_tready;

  logic [2*DATA_WIDTH-1:0] o_in0_tdata;
  logic [2*DATA_WIDTH-1:0] o_in1_tdata;
  logic [DATA_WIDTH-1:0]   o_scale0;
  logic [DATA_WIDTH-1:0]   o_scale1;
  logic                    o_tvalid;
  logic                    o_tlast;
  logic                    o_tready;

  modport slave (
    input  cfg_step, cfg_load, i_tdata, i_tvalid, i_tlast, o_tready,
    output i_tready, o_in0_tdata, o_in1_tdata, o_scale0, o_scale1, o_tvalid, o_tlast
  );

  modport master (
    output cfg_step, cfg_load, i_tdata, i_tvalid, i_tlast, o_tready,
    input  i_tready, o_in0_tdata, o_in1_tdata, o_scale0, o_scale1, o_tvalid, o_tlast
  );
endinterface

// File: rtl/lin1d_sched.sv
// Rate-change scheduler for a two-tap linear interpolator: holds the sample pair (x[n], x[n+1])
// and a fractional phase mu, emitting (x[n], x[n+1], ONE-mu, mu) once per output sample.
module lin1d_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 10,
  parameter int INT_BITS   = 4
) (
  input  logic           clk,
  input  logic           reset,
  lin1d_sched_if.slave   bus
);
  localparam int STEP_W = INT_BITS + FRAC_BITS;
  localparam int ACC_W  = STEP_W + 1;
  localparam int K_W    = ACC_W - FRAC_BITS;
  localparam int ONE    = 1 << FRAC_BITS;

  typedef enum logic [1:0] {PRIME0, PRIME1, EMIT, SKIP} state_t;

  state_t                  state;
  logic                    run;
  logic [FRAC_BITS-1:0]    mu;
  logic [STEP_W-1:0]       step_r;
  logic [2*DATA_WIDTH-1:0] in0;
  logic [2*DATA_WIDTH-1:0] in1;
  logic                    last_pend;
  logic [K_W-1:0]          cnt;

  logic [ACC_W-1:0]        acc;
  logic [K_W-1:0]          k;
  logic [FRAC_BITS-1:0]    mu_next;
  logic [FRAC_BITS:0]      scale0;
  logic                    in_hs;
  logic                    out_hs;

  // Phase advance: integer part is how many input samples to step over, fraction is the new mu.
  assign acc     = ACC_W'(mu) + ACC_W'(step_r);
  assign k       = acc[ACC_W-1:FRAC_BITS];
  assign mu_next = acc[FRAC_BITS-1:0];
  assign scale0  = (FRAC_BITS+1)'(ONE) - {1'b0, mu};

  // NOTE: run holds i_tready low while reset is asserted and until the first edge after release,
  // so the source never sees a ready that was decoded from a state still held in reset.
  assign bus.i_tready    = run && (state != EMIT);
  assign bus.o_tvalid    = (state == EMIT);
  assign bus.o_tlast     = (state == EMIT) && last_pend && (k != '0);
  assign bus.o_in0_tdata = in0;
  assign bus.o_in1_tdata = in1;
  assign bus.o_scale0    = DATA_WIDTH'(scale0);
  assign bus.o_scale1    = DATA_WIDTH'(mu);

  assign in_hs  = bus.i_tvalid && bus.i_tready;
  assign out_hs = bus.o_tvalid && bus.o_tready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PRIME0;
      run       <= 1'b0;
      mu        <= '0;
      step_r    <= STEP_W'(ONE);
      in0       <= '0;
      in1       <= '0;
      last_pend <= 1'b0;
      cnt       <= '0;
    end else begin
      run <= 1'b1;
      if (bus.cfg_load) step_r <= bus.cfg_step;

      unique case (state)
        PRIME0: if (in_hs && !bus.i_tlast) begin
          in0   <= bus.i_tdata;
          state <= PRIME1;
        end
        PRIME1: if (in_hs) begin
          in1       <= bus.i_tdata;
          last_pend <= bus.i_tlast;
          state     <= EMIT;
        end
        EMIT: if (out_hs) begin
          mu <= mu_next;
          if (bus.o_tlast) begin
            mu        <= '0;
            last_pend <= 1'b0;
            state     <= PRIME0;
          end else if (k != '0) begin
            cnt   <= k;
            state <= SKIP;
          end
        end
        SKIP: if (in_hs) begin
          in0       <= in1;
          in1       <= bus.i_tdata;
          last_pend <= bus.i_tlast;
          cnt       <= cnt - K_W'(1);
          // A packet end cuts the skip short; last_pend then flags the next beat as the last.
          if (cnt == K_W'(1) || bus.i_tlast) state <= EMIT;
        end
        default: state <= PRIME0;
      endcase
    end
  end
endmodule

// File: tb/tb_lin1d_sched.sv
// Scoreboard bench for lin1d_sched: directed packets push expected beats, a negedge monitor
// pops and compares every accepted output beat and checks outputs hold while stalled.
module tb_lin1d_sched;
  localparam int DW = 16;

  typedef struct packed {
    logic [2*DW-1:0] in0;
    logic [2*DW-1:0] in1;
    logic [DW-1:0]   s0;
    logic [DW-1:0]   s1;
    logic            last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   rand_ready = 1'b0;
  int   checks = 0;
  int   errors = 0;
  beat_t sb[$];

  lin1d_sched_if #(.DATA_WIDTH(DW), .FRAC_BITS(10), .INT_BITS(4)) bus ();

  lin1d_sched #(.DATA_WIDTH(DW), .FRAC_BITS(10), .INT_BITS(4)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] A = 32'h1111_000A, B = 32'h2222_000B, C = 32'h3333_000C;
  localparam logic [31:0] D = 32'h4444_000D, E = 32'h5555_000E, F = 32'h6666_000F;
  localparam logic [31:0] X = 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input logic [31:0] i0, input logic [31:0] i1,
                             input int s0, input int s1, input logic last);
    beat_t b;
    b.in0 = i0; b.in1 = i1; b.s0 = DW'(s0); b.s1 = DW'(s1); b.last = last;
    sb.push_back(b);
  endtask

  // Monitor: compare on each accepted beat, and check held outputs on each stalled cycle.
  beat_t held;
  bit    stalled = 1'b0;
  always @(negedge clk) begin
    beat_t cur, exp;
    cur = '{bus.o_in0_tdata, bus.o_in1_tdata, bus.o_scale0, bus.o_scale1, bus.o_tlast};
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", 64'(bus.o_tvalid), 64'd1);
        check("hold_beat", 64'(cur[96:0] ^ held[96:0]), 64'd0);
        check("hold_last", 64'(cur.last), 64'(held.last));
      end
      stalled = 1'b0;
      if (bus.o_tvalid) begin
        held    = cur;
        stalled = !bus.o_tready;
        if (bus.o_tready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got in0=%h in1=%h s0=%0d s1=%0d last=%0d expected none",
                     cur.in0, cur.in1, cur.s0, cur.s1, cur.last);
          end else begin
            exp = sb.pop_front();
            check("beat_in0", 64'(cur.in0), 64'(exp.in0));
            check("beat_in1", 64'(cur.in1), 64'(exp.in1));
            check("beat_scale0", 64'(cur.s0), 64'(exp.s0));
            check("beat_scale1", 64'(cur.s1), 64'(exp.s1));
            check("beat_tlast", 64'(cur.last), 64'(exp.last));
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    bus.o_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_step(input logic [13:0] s);
    bus.cfg_step = s;
    bus.cfg_load = 1'b1;
    @(posedge clk);
    #1;
    bus.cfg_load = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    bit ok = 1'b0;
    int n = 0;
    bus.i_tdata  = d;
    bus.i_tlast  = l;
    bus.i_tvalid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.i_tready;
      @(posedge clk);
      n++;
    end
    #1;
    bus.i_tvalid = 1'b0;
    bus.i_tlast  = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no i_tready for %h expected acceptance", d);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic run_step300();
    do_reset();
    load_step(14'h300);
    expect_beat(A, B, 1024, 0, 0);
    expect_beat(A, B, 256, 768, 0);
    expect_beat(B, C, 512, 512, 0);
    expect_beat(C, D, 768, 256, 0);
    expect_beat(D, E, 1024, 0, 0);
    expect_beat(D, E, 256, 768, 1);
    send(A, 0); send(B, 0); send(C, 0); send(D, 0); send(E, 1);
    drain();
  endtask

  initial begin
    bus.cfg_step = '0;
    bus.cfg_load = 1'b0;
    bus.i_tdata  = '0;
    bus.i_tvalid = 1'b0;
    bus.i_tlast  = 1'b0;
    bus.o_tready = 1'b1;

    // Reset state, sampled while reset is held.
    @(negedge clk);
    check("rst_tvalid", 64'(bus.o_tvalid), 64'd0);
    check("rst_tlast", 64'(bus.o_tlast), 64'd0);
    check("rst_iready", 64'(bus.i_tready), 64'd0);
    check("rst_scale0", 64'(bus.o_scale0), 64'd1024);
    check("rst_scale1", 64'(bus.o_scale1), 64'd0);
    check("rst_in0", 64'(bus.o_in0_tdata), 64'd0);
    check("rst_in1", 64'(bus.o_in1_tdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_iready", 64'(bus.i_tready), 64'd1);

    // Unity step: one output per input pair.
    do_reset();
    load_step(14'h400);
    expect_beat(A, B, 1024, 0, 0);
    expect_beat(B, C, 1024, 0, 0);
    expect_beat(C, D, 1024, 0, 1);
    send(A, 0); send(B, 0); send(C, 0); send(D, 1);
    drain();

    // Half step: interpolated midpoints, tlast on the final fractional beat.
    do_reset();
    load_step(14'h200);
    expect_beat(A, B, 1024, 0, 0);
    expect_beat(A, B, 512, 512, 0);
    expect_beat(B, C, 1024, 0, 0);
    expect_beat(B, C, 512, 512, 1);
    send(A, 0); send(B, 0); send(C, 1);
    drain();

    // Fractional step 0.75 with full-rate sink.
    run_step300();

    // Decimate by two: every other sample skipped.
    do_reset();
    load_step(14'h800);
    expect_beat(A, B, 1024, 0, 0);
    expect_beat(C, D, 1024, 0, 0);
    expect_beat(E, F, 1024, 0, 1);
    send(A, 0); send(B, 0); send(C, 0); send(D, 0); send(E, 0); send(F, 1);
    drain();

    // Same 0.75 sequence under random backpressure.
    rand_ready = 1'b1;
    run_step300();
    rand_ready = 1'b0;

    // A lone tlast sample in PRIME0 is dropped; default step after reset is unity.
    do_reset();
    expect_beat(A, B, 1024, 0, 1);
    send(X, 1); send(A, 0); send(B, 1);
    drain();

    // Reset while skipping discards held samples.
    do_reset();
    load_step(14'h800);
    expect_beat(A, B, 1024, 0, 0);
    send(A, 0); send(B, 0);
    drain();
    send(C, 0);
    @(negedge clk);
    check("skip_iready", 64'(bus.i_tready), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_tvalid", 64'(bus.o_tvalid), 64'd0);
    check("midrst_iready", 64'(bus.i_tready), 64'd0);
    check("midrst_in0", 64'(bus.o_in0_tdata), 64'd0);
    check("midrst_in1", 64'(bus.o_in1_tdata), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    expect_beat(E, F, 1024, 0, 1);
    send(E, 0); send(F, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
